mby_msh_row_rd_req_inj: RTL and testbench



---
 rtl/mby_msh_row_rd_req_inj.sv | 124 ++++++++++++
 tb/tb_mby_msh_row_rd_req_inj.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mby_msh_row_rd_req_inj.sv
// Mesh row read-request injector: request FIFO, per-column credit flow control, rolling IDs.
// Optional stall counter output enabled by `define MBY_MSH_RD_INJ_STALL_CNT_EN.
module mby_msh_row_rd_req_inj #(
    parameter int FIFO_DEPTH = 4,
    parameter int CRDT_MAX   = 4,
    parameter int CRDT_W     = $clog2(CRDT_MAX + 1)
) (
    input  logic        cclk,
    input  logic        rst,
    input  logic [2:0]  i_mpg_col,
    input  logic        i_req_vld,
    output logic        o_req_rdy,
    input  logic [2:0]  i_req_node_col,
    input  logic [3:0]  i_req_node_row,
    input  logic [19:0] i_req_mem_addr,
    input  logic        i_req_sema_vld,
    input  logic        i_req_sema_val,
    output logic [48:0] o_row_rd_req,
    input  logic [7:0]  i_crdt_rtn,
    output logic        o_crdt_err,
    output logic        o_idle
`ifdef MBY_MSH_RD_INJ_STALL_CNT_EN
    ,
    output logic [15:0] o_stall_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CRDT_W-1:0] CMAX = CRDT_W'(CRDT_MAX);

    typedef struct packed {
        logic [2:0]  node_col;
        logic [3:0]  node_row;
        logic [19:0] mem_addr;
        logic        sema_vld;
        logic        sema_val;
    } entry_t;

    // Returns {overflow, next}; a return at the ceiling saturates and flags overflow.
    function automatic logic [CRDT_W:0] crdt_upd(input logic [CRDT_W-1:0] cur,
                                                 input logic inc, input logic dec);
        logic [CRDT_W:0] r;
        r = {1'b0, cur};
        if (inc && !dec) begin
            if (cur == CMAX) r = {1'b1, cur};
            else             r = {1'b0, cur + 1'b1};
        end else if (dec && !inc) begin
            r = {1'b0, cur - 1'b1};
        end
        return r;
    endfunction

    entry_t            mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [CRDT_W-1:0] crdt [8];
    logic [CRDT_W-1:0] crdt_nxt [8];
    logic              ovf;
    logic [15:0]       id_cnt;
    logic [48:0]       row_rd_req;
    logic              full, empty, push, pop, all_full;
    entry_t            head, entry_in;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head     = mem[rd_ptr[AW-1:0]];
    assign push     = i_req_vld && !full;
    assign pop      = !empty && (crdt[head.node_col] != '0);
    assign entry_in = '{i_req_node_col, i_req_node_row, i_req_mem_addr,
                        i_req_sema_vld, i_req_sema_val};

    assign o_req_rdy    = !full;
    assign o_row_rd_req = row_rd_req;
    assign o_idle       = empty && all_full;

    always_comb begin
        logic [CRDT_W:0] u;
        ovf      = 1'b0;
        all_full = 1'b1;
        for (int c = 0; c < 8; c++) begin
            u           = crdt_upd(crdt[c], i_crdt_rtn[c], pop && (head.node_col == 3'(c)));
            crdt_nxt[c] = u[CRDT_W-1:0];
            ovf         = ovf | u[CRDT_W];
            all_full    = all_full & (crdt[c] == CMAX);
        end
    end

    // Storage is data-only; validity is carried by the pointers.
    always_ff @(posedge cclk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= entry_in;
    end

    always_ff @(posedge cclk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            id_cnt     <= '0;
            o_crdt_err <= 1'b0;
            row_rd_req <= '0;
            for (int c = 0; c < 8; c++) crdt[c] <= CMAX;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (ovf)  o_crdt_err <= 1'b1;
            for (int c = 0; c < 8; c++) crdt[c] <= crdt_nxt[c];
            if (pop) begin
                rd_ptr     <= rd_ptr + 1'b1;
                id_cnt     <= id_cnt + 16'd1;
                row_rd_req <= {1'b1, id_cnt, i_mpg_col, head.node_col, head.node_row,
                               head.mem_addr, head.sema_vld, head.sema_val};
            end else begin
                row_rd_req[48] <= 1'b0;
            end
        end
    end

`ifdef MBY_MSH_RD_INJ_STALL_CNT_EN
    // Counts cycles where a queued head is blocked purely by missing credit.
    always_ff @(posedge cclk or posedge rst) begin
        if (rst)
            o_stall_cnt <= '0;
        else if (!empty && (crdt[head.node_col] == '0) && (o_stall_cnt != 16'hFFFF))
            o_stall_cnt <= o_stall_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_mby_msh_row_rd_req_inj.sv
// Bench for mby_msh_row_rd_req_inj: directed scenarios plus random traffic against a
// queue-based reference model; optional stall counter checked when the macro is defined.
module tb_mby_msh_row_rd_req_inj;
    localparam int DEPTH = 4;
    localparam int CMAX  = 4;

    logic        cclk = 0;
    logic        rst = 1;
    logic [2:0]  i_mpg_col = 3'd2;
    logic        i_req_vld = 0;
    logic        o_req_rdy;
    logic [2:0]  i_req_node_col = 0;
    logic [3:0]  i_req_node_row = 0;
    logic [19:0] i_req_mem_addr = 0;
    logic        i_req_sema_vld = 0;
    logic        i_req_sema_val = 0;
    logic [48:0] o_row_rd_req;
    logic [7:0]  i_crdt_rtn = 0;
    logic        o_crdt_err;
    logic        o_idle;
`ifdef MBY_MSH_RD_INJ_STALL_CNT_EN
    logic [15:0] o_stall_cnt;
`endif

    mby_msh_row_rd_req_inj #(.FIFO_DEPTH(DEPTH), .CRDT_MAX(CMAX)) dut (
        .cclk(cclk), .rst(rst), .i_mpg_col(i_mpg_col),
        .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
        .i_req_node_col(i_req_node_col), .i_req_node_row(i_req_node_row),
        .i_req_mem_addr(i_req_mem_addr), .i_req_sema_vld(i_req_sema_vld),
        .i_req_sema_val(i_req_sema_val), .o_row_rd_req(o_row_rd_req),
        .i_crdt_rtn(i_crdt_rtn), .o_crdt_err(o_crdt_err), .o_idle(o_idle)
`ifdef MBY_MSH_RD_INJ_STALL_CNT_EN
        , .o_stall_cnt(o_stall_cnt)
`endif
    );

    always #5 cclk = ~cclk;

    typedef struct {
        bit [2:0]  col;
        bit [3:0]  row;
        bit [19:0] addr;
        bit        sv;
        bit        sval;
    } req_t;

    req_t        q[$];
    int          crd[8];
    bit [15:0]   m_id;
    bit          m_err;
    bit [48:0]   m_out;
    int          m_stall;
    int          tests = 0;
    int          fails = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic bit [48:0] pack(bit v, bit [15:0] id, bit [2:0] mc, req_t r);
        return {v, id, mc, r.col, r.row, r.addr, r.sv, r.sval};
    endfunction

    function automatic bit m_idle();
        bit ok = (q.size() == 0);
        for (int c = 0; c < 8; c++) if (crd[c] != CMAX) ok = 0;
        return ok;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int c = 0; c < 8; c++) crd[c] = CMAX;
        m_id = 0; m_err = 0; m_out = '0; m_stall = 0;
    endtask

    // Predict the next clock edge from current inputs, take it, then compare.
    task automatic step();
        bit   push, pop;
        req_t h, n;
        push = i_req_vld && (q.size() < DEPTH);
        pop  = (q.size() > 0) && (crd[q[0].col] > 0);
        if (q.size() > 0) h = q[0];
        if (q.size() > 0 && crd[h.col] == 0 && m_stall < 16'hFFFF) m_stall++;
        if (pop) begin
            m_out = pack(1'b1, m_id, i_mpg_col, h);
            m_id++;
        end else begin
            m_out[48] = 1'b0;
        end
        for (int c = 0; c < 8; c++) begin
            bit dec = pop && (h.col == c);
            bit inc = i_crdt_rtn[c];
            if (inc && !dec) begin
                if (crd[c] == CMAX) m_err = 1;
                else crd[c]++;
            end else if (dec && !inc) begin
                crd[c]--;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) begin
            n.col = i_req_node_col; n.row = i_req_node_row; n.addr = i_req_mem_addr;
            n.sv = i_req_sema_vld; n.sval = i_req_sema_val;
            q.push_back(n);
        end
        @(posedge cclk); #1;
        check("row_rd_req", 64'(o_row_rd_req), 64'(m_out));
        check("req_rdy", 64'(o_req_rdy), 64'(q.size() < DEPTH));
        check("idle", 64'(o_idle), 64'(m_idle()));
        check("crdt_err", 64'(o_crdt_err), 64'(m_err));
`ifdef MBY_MSH_RD_INJ_STALL_CNT_EN
        check("stall_cnt", 64'(o_stall_cnt), 64'(m_stall));
`endif
    endtask

    task automatic send(input bit [2:0] col, input bit [3:0] row, input bit [19:0] addr);
        int n = 0;
        i_req_vld = 1; i_req_node_col = col; i_req_node_row = row; i_req_mem_addr = addr;
        i_req_sema_vld = addr[0]; i_req_sema_val = addr[1];
        while (!o_req_rdy && n < 50) begin step(); n++; end
        if (n >= 50) check("send_timeout", 64'd0, 64'd1);
        step();
        i_req_vld = 0;
    endtask

    task automatic do_reset();
        i_req_vld = 0; i_crdt_rtn = 0;
        #2 rst = 1;
        #1;
        check("rst_out", 64'(o_row_rd_req), 64'd0);
        check("rst_rdy", 64'(o_req_rdy), 64'd1);
        check("rst_err", 64'(o_crdt_err), 64'd0);
        check("rst_idle", 64'(o_idle), 64'd1);
`ifdef MBY_MSH_RD_INJ_STALL_CNT_EN
        check("rst_stall", 64'(o_stall_cnt), 64'd0);
`endif
        model_reset();
        @(negedge cclk) rst = 0;
        @(posedge cclk); #1;
    endtask

    initial begin
        req_t  r;
        int    pushed, issued, cyc, n;
        model_reset();
        repeat (2) @(posedge cclk);
        #1;
        do_reset();

        // Single request latency and field integrity.
        send(3'd5, 4'd3, 20'h12345);
        step();
        r.col = 5; r.row = 3; r.addr = 20'h12345; r.sv = 1; r.sval = 0;
        check("single_req", 64'(o_row_rd_req), 64'(pack(1'b1, 16'd0, 3'd2, r)));
        check("single_busy", 64'(o_idle), 64'd0);
        step();

        // Traffic then asynchronous mid-cycle reset.
        send(3'd4, 4'd1, 20'h00ABC);
        do_reset();

        // Credit exhaustion on column 1.
        for (int i = 0; i < 5; i++) send(3'd1, 4'(i), 20'(i * 16));
        repeat (3) step();
        i_crdt_rtn = 8'h02; step();
        i_crdt_rtn = 8'h00; step();
        check("exhaust_vld", 64'(o_row_rd_req[48]), 64'd1);
        check("exhaust_id4", 64'(o_row_rd_req[47:32]), 64'd4);
`ifdef MBY_MSH_RD_INJ_STALL_CNT_EN
        check("exhaust_stall", 64'(o_stall_cnt), 64'd4);
`endif
        repeat (2) step();

        // Head-of-line blocking and backpressure.
        do_reset();
        for (int i = 0; i < 4; i++) send(3'd0, 4'd0, 20'(i));
        send(3'd0, 4'd9, 20'hF0000);
        for (int i = 0; i < 3; i++) send(3'd7, 4'(i), 20'(20'h70000 + i));
        repeat (3) step();
        check("hol_full", 64'(o_req_rdy), 64'd0);
        check("hol_blocked", 64'(o_row_rd_req[48]), 64'd0);
        i_crdt_rtn = 8'h01; step();
        i_crdt_rtn = 8'h00;
        repeat (6) step();
        check("hol_drained_rdy", 64'(o_req_rdy), 64'd1);

        // Simultaneous issue/return on column 2, overflow on column 6.
        do_reset();
        for (int i = 0; i < 3; i++) send(3'd2, 4'd2, 20'(i));
        repeat (2) step();
        send(3'd2, 4'd5, 20'h22222);
        i_crdt_rtn = 8'h04; step();
        i_crdt_rtn = 8'h00;
        check("same_cycle_issue", 64'(o_row_rd_req[48]), 64'd1);
        send(3'd2, 4'd6, 20'h33333);
        step();
        check("col2_last_credit", 64'(o_row_rd_req[48]), 64'd1);
        i_crdt_rtn = 8'h40; step();
        i_crdt_rtn = 8'h00;
        check("ovf_set", 64'(o_crdt_err), 64'd1);
        repeat (3) step();
        check("ovf_sticky", 64'(o_crdt_err), 64'd1);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            i_req_vld      = ($urandom % 3) != 0;
            i_req_node_col = 3'($urandom);
            i_req_node_row = 4'($urandom);
            i_req_mem_addr = 20'($urandom);
            i_req_sema_vld = 1'($urandom);
            i_req_sema_val = 1'($urandom);
            for (int c = 0; c < 8; c++)
                i_crdt_rtn[c] = (crd[c] < CMAX) && (($urandom % 2) == 0);
            step();
        end
        i_req_vld = 0;
        for (int i = 0; i < 40; i++) begin
            for (int c = 0; c < 8; c++) i_crdt_rtn[c] = (crd[c] < CMAX);
            step();
        end
        i_crdt_rtn = 0; step();
        check("rand_idle", 64'(o_idle), 64'd1);

        // ID wrap with credits returned one cycle after each issue.
        do_reset();
        pushed = 0; issued = 0; cyc = 0;
        i_req_node_col = 3'd3; i_req_node_row = 4'd1;
        while (issued < 65536 && cyc < 70000) begin
            i_req_vld      = (pushed < 65536);
            i_req_mem_addr = 20'($urandom);
            i_crdt_rtn     = {4'b0, o_row_rd_req[48], 3'b0};
            n = int'(i_req_vld && o_req_rdy);
            step();
            pushed += n;
            if (o_row_rd_req[48]) issued++;
            cyc++;
        end
        check("wrap_issued", 64'(issued), 64'd65536);
        i_req_vld = 0;
        i_crdt_rtn = {4'b0, o_row_rd_req[48], 3'b0};
        step();
        i_crdt_rtn = 0;
        send(3'd3, 4'd4, 20'hABCDE);
        n = 0;
        while (!o_row_rd_req[48] && n < 20) begin step(); n++; end
        check("wrap_vld", 64'(o_row_rd_req[48]), 64'd1);
        check("wrap_id0", 64'(o_row_rd_req[47:32]), 64'd0);
        i_crdt_rtn = 8'h08; step();
        i_crdt_rtn = 8'h00; step();
        check("wrap_idle", 64'(o_idle), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
